// File: rtl/block_stream_ctrl_if.sv
// Bundle of the character, checker and verdict handshakes around block_stream_ctrl.
// The master modport is the controller's view; the slave modport is the view of
// the surrounding producers, checker and verdict consumer.
interface block_stream_ctrl_if;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_ready;
  logic       chk_clr;
  logic       chk_en;
  logic [7:0] chk_in;
  logic       chk_result;
  logic       res_valid;
  logic       res_ready;
  logic       res_src;
  logic       res_ok;
  logic [7:0] res_len;

  modport master (
    input  a_valid, a_data, b_valid, b_data, chk_result, res_ready,
    output a_ready, b_ready, chk_clr, chk_en, chk_in,
           res_valid, res_src, res_ok, res_len
  );

  modport slave (
    output a_valid, a_data, b_valid, b_data, chk_result, res_ready,
    input  a_ready, b_ready, chk_clr, chk_en, chk_in,
           res_valid, res_src, res_ok, res_len
  );
endinterface

// File: rtl/block_stream_ctrl.sv
// Sentence-level controller sharing one begin/end nesting checker between two
// character sources. A source owns the checker for a whole sentence: the checker
// is cleared, the sentence streamed in, a flushing space appended, and the
// verdict reported on a held result handshake. Round-robin arbitration on ties.
module block_stream_ctrl #(
  parameter int         MAX_LEN = 200,
  parameter logic [7:0] TERM    = 8'h0A
) (
  input  logic                  clk,
  input  logic                  reset,
  block_stream_ctrl_if.master   bus,
  output logic                  busy
);

  localparam logic [7:0] FLUSH_CHAR = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    STREAM,
    FLUSH,
    SAMPLE,
    REPORT
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       owner;
  logic       owner_next;
  logic       last_owner;
  logic [7:0] len_cnt;
  logic       overflow;
  logic       src_valid;
  logic [7:0] src_data;
  logic       xfer;
  logic       is_term;

  // Owner's stream seen through a single mux; a transfer only exists in STREAM,
  // where the owner's ready is the only one raised.
  assign src_valid = owner ? bus.b_valid : bus.a_valid;
  assign src_data  = owner ? bus.b_data  : bus.a_data;
  assign xfer      = (state == STREAM) && src_valid;
  assign is_term   = (src_data == TERM);

  // State and owner registers; the owner only changes when leaving IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= 1'b0;
    end else begin
      state <= state_next;
      owner <= owner_next;
    end
  end

  // Next-state logic, including the round-robin pick of the new owner on a tie.
  always_comb begin
    state_next = state;
    owner_next = owner;
    case (state)
      IDLE: begin
        if (bus.a_valid && bus.b_valid) begin
          owner_next = ~last_owner;
          state_next = GRANT;
        end else if (bus.a_valid) begin
          owner_next = 1'b0;
          state_next = GRANT;
        end else if (bus.b_valid) begin
          owner_next = 1'b1;
          state_next = GRANT;
        end
      end
      GRANT:   state_next = STREAM;
      STREAM:  if (xfer && is_term) state_next = FLUSH;
      FLUSH:   state_next = SAMPLE;
      SAMPLE:  state_next = REPORT;
      REPORT:  if (bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decoded outputs: only the owner sees ready, and only while streaming.
  always_comb begin
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    busy        = (state != IDLE);
    if (state == STREAM) begin
      bus.a_ready = ~owner;
      bus.b_ready = owner;
    end
  end

  // Checker clear is high for the GRANT cycle and held high out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.chk_clr <= 1'b1;
    end else begin
      bus.chk_clr <= (state_next == GRANT);
    end
  end

  // Forward each accepted character one cycle later; the terminator becomes a space.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.chk_en <= 1'b0;
      bus.chk_in <= 8'h00;
    end else begin
      bus.chk_en <= 1'b0;
      if (xfer) begin
        bus.chk_en <= 1'b1;
        bus.chk_in <= is_term ? FLUSH_CHAR : src_data;
      end
    end
  end

  // Saturating sentence length and sticky overflow once the length passes MAX_LEN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_cnt  <= 8'h00;
      overflow <= 1'b0;
    end else if (state == GRANT) begin
      len_cnt  <= 8'h00;
      overflow <= 1'b0;
    end else if (xfer && !is_term) begin
      if (len_cnt != 8'hFF) begin
        len_cnt <= len_cnt + 8'd1;
      end
      if (int'(len_cnt) >= MAX_LEN) begin
        overflow <= 1'b1;
      end
    end
  end

  // Verdict capture at the end of SAMPLE, held until the consumer accepts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.res_valid <= 1'b0;
      bus.res_src   <= 1'b0;
      bus.res_ok    <= 1'b0;
      bus.res_len   <= 8'h00;
      last_owner    <= 1'b1;
    end else if (state == SAMPLE) begin
      bus.res_valid <= 1'b1;
      bus.res_src   <= owner;
      bus.res_ok    <= bus.chk_result & ~overflow;
      bus.res_len   <= len_cnt;
      last_owner    <= owner;
    end else if ((state == REPORT) && bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_block_stream_ctrl.sv
// Directed bench for block_stream_ctrl. Two instances run in lockstep on the same
// stimulus: the default MAX_LEN and MAX_LEN = 4. A stand-in checker per instance
// reports the chosen verdict only after sampling a space, and 0 after other chars.
module tb_block_stream_ctrl;

  typedef struct packed {
    logic       src;
    logic       ok;
    logic [7:0] len;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic busy4;
  logic stub_verdict;

  int tests_run    = 0;
  int tests_failed = 0;
  int b_ready_hi   = 0;

  logic [7:0] seq[$];
  logic [7:0] seq4[$];
  res_t       res_q[$];

  block_stream_ctrl_if bus ();
  block_stream_ctrl_if bus4 ();

  block_stream_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master),
    .busy  (busy)
  );

  block_stream_ctrl #(.MAX_LEN(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.master),
    .busy  (busy4)
  );

  assign bus4.a_valid   = bus.a_valid;
  assign bus4.a_data    = bus.a_data;
  assign bus4.b_valid   = bus.b_valid;
  assign bus4.b_data    = bus.b_data;
  assign bus4.res_ready = bus.res_ready;

  always #5 clk = ~clk;

  // Stand-in checker for the default instance.
  always @(posedge clk or negedge reset) begin
    if (!reset) bus.chk_result <= 1'b0;
    else if (bus.chk_clr) bus.chk_result <= 1'b0;
    else if (bus.chk_en) bus.chk_result <= (bus.chk_in == 8'h20) ? stub_verdict : 1'b0;
  end

  // Stand-in checker for the MAX_LEN = 4 instance.
  always @(posedge clk or negedge reset) begin
    if (!reset) bus4.chk_result <= 1'b0;
    else if (bus4.chk_clr) bus4.chk_result <= 1'b0;
    else if (bus4.chk_en) bus4.chk_result <= (bus4.chk_in == 8'h20) ? stub_verdict : 1'b0;
  end

  // Record what the checkers sample and every accepted verdict.
  always @(posedge clk) begin
    if (reset) begin
      if (bus.chk_en) seq.push_back(bus.chk_in);
      if (bus4.chk_en) seq4.push_back(bus4.chk_in);
      if (bus.res_valid && bus.res_ready) res_q.push_back(res_t'({bus.res_src, bus.res_ok, bus.res_len}));
    end
  end

  // Count cycles in which B is offered ready.
  always @(negedge clk) begin
    if (bus.b_ready) b_ready_hi++;
  end

  // Watchdog so a stuck design still ends the run.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Send a string on one source, one char per offered ready; returns at the
  // negedge after the last transfer.
  task automatic send_str(input bit src, input string s);
    int guard;
    for (int i = 0; i < s.len(); i++) begin
      guard = 0;
      if (src) begin
        bus.b_valid = 1'b1;
        bus.b_data  = s[i];
      end else begin
        bus.a_valid = 1'b1;
        bus.a_data  = s[i];
      end
      while (((src ? bus.b_ready : bus.a_ready) !== 1'b1) && guard < 60) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 60) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL send_timeout src=%0d idx=%0d: ready=0, required 1", src, i);
      end
      @(negedge clk);
    end
    if (src) bus.b_valid = 1'b0;
    else bus.a_valid = 1'b0;
  endtask

  // Pulse res_ready for one edge.
  task automatic release_result();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.a_valid = 1'b0;  bus.a_data = 8'h00;
    bus.b_valid = 1'b0;  bus.b_data = 8'h00;
    bus.res_ready = 1'b0;
    stub_verdict = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.chk_clr, bus.chk_en, bus.chk_in, busy, bus.a_ready, bus.b_ready} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: clr=%b en=%b in=%h busy=%b ar=%b br=%b, required 1 0 00 0 0 0",
               bus.chk_clr, bus.chk_en, bus.chk_in, busy, bus.a_ready, bus.b_ready);
    end
    tests_run++;
    if ({bus.res_valid, bus.res_src, bus.res_ok, bus.res_len} !== 11'h000) begin
      tests_failed++;
      $display("[TB] FAIL reset_res: valid=%b src=%b ok=%b len=%0d, required all 0",
               bus.res_valid, bus.res_src, bus.res_ok, bus.res_len);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus.chk_clr, busy} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: clr=%b busy=%b, required 0 0", bus.chk_clr, busy);
    end
  endtask

  task automatic test_basic();
    string exp = "begin end ";
    int    base  = seq.size();
    int    base4 = seq4.size();
    stub_verdict = 1'b1;
    send_str(1'b0, "begin end\n");
    tests_run++;
    if (bus.res_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL basic_valid_t0: res_valid=%b, required 0", bus.res_valid);
    end
    @(negedge clk);
    tests_run++;
    if (bus.res_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL basic_valid_t1: res_valid=%b, required 0", bus.res_valid);
    end
    @(negedge clk);
    tests_run++;
    if (bus.res_valid !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL basic_valid_t2: res_valid=%b, required 1", bus.res_valid);
    end
    tests_run++;
    if ({bus.res_src, bus.res_ok, bus.res_len} !== {1'b0, 1'b1, 8'd9}) begin
      tests_failed++;
      $display("[TB] FAIL basic_result: src=%b ok=%b len=%0d, required 0 1 9", bus.res_src, bus.res_ok, bus.res_len);
    end
    tests_run++;
    if ({bus4.res_ok, bus4.res_len} !== {1'b0, 8'd9}) begin
      tests_failed++;
      $display("[TB] FAIL basic_result_max4: ok=%b len=%0d, required 0 9", bus4.res_ok, bus4.res_len);
    end
    tests_run++;
    if (seq.size() - base != 10) begin
      tests_failed++; $display("[TB] FAIL basic_seq_len: %0d chars, required 10", seq.size() - base);
    end else begin
      for (int i = 0; i < 10; i++) begin
        tests_run++;
        if (seq[base + i] !== exp[i]) begin
          tests_failed++; $display("[TB] FAIL basic_seq[%0d]: %h, required %h", i, seq[base + i], exp[i]);
        end
      end
    end
    tests_run++;
    if (seq4.size() - base4 != 10) begin
      tests_failed++; $display("[TB] FAIL basic_seq4_len: %0d chars, required 10", seq4.size() - base4);
    end
    release_result();
    tests_run++;
    if ({bus.res_valid, busy} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL basic_release: valid=%b busy=%b, required 0 0", bus.res_valid, busy);
    end
  endtask

  task automatic test_tie();
    int snap;
    int snap_after_a = 0;
    int rbase;
    int guard = 0;
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    stub_verdict  = 1'b1;
    bus.res_ready = 1'b1;
    rbase = res_q.size();
    snap  = b_ready_hi;
    fork
      begin
        send_str(1'b0, "end\n");
        snap_after_a = b_ready_hi;
      end
      send_str(1'b1, "begin end\n");
    join
    tests_run++;
    if (snap_after_a - snap != 0) begin
      tests_failed++; $display("[TB] FAIL tie_b_ready_during_a: %0d cycles high, required 0", snap_after_a - snap);
    end
    while (res_q.size() - rbase < 2 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.res_ready = 1'b0;
    tests_run++;
    if (res_q.size() - rbase != 2) begin
      tests_failed++; $display("[TB] FAIL tie_result_count: %0d, required 2", res_q.size() - rbase);
    end else begin
      tests_run++;
      if (res_q[rbase] !== res_t'({1'b0, 1'b1, 8'd3})) begin
        tests_failed++; $display("[TB] FAIL tie_first: %h, required %h", res_q[rbase], res_t'({1'b0, 1'b1, 8'd3}));
      end
      tests_run++;
      if (res_q[rbase + 1] !== res_t'({1'b1, 1'b1, 8'd9})) begin
        tests_failed++; $display("[TB] FAIL tie_second: %h, required %h", res_q[rbase + 1], res_t'({1'b1, 1'b1, 8'd9}));
      end
    end
  endtask

  task automatic test_hold();
    int guard = 0;
    stub_verdict = 1'b0;
    send_str(1'b0, "begin\n");
    while (bus.res_valid !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    tests_run++;
    if ({bus.res_valid, bus.res_src, bus.res_ok, bus.res_len} !== {1'b1, 1'b0, 1'b0, 8'd5}) begin
      tests_failed++;
      $display("[TB] FAIL hold_result: valid=%b src=%b ok=%b len=%0d, required 1 0 0 5",
               bus.res_valid, bus.res_src, bus.res_ok, bus.res_len);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.res_valid, bus.res_src, bus.res_ok, bus.res_len, busy} !== {1'b1, 1'b0, 1'b0, 8'd5, 1'b1}) begin
        tests_failed++;
        $display("[TB] FAIL hold_stable[%0d]: valid=%b src=%b ok=%b len=%0d busy=%b, required 1 0 0 5 1",
                 i, bus.res_valid, bus.res_src, bus.res_ok, bus.res_len, busy);
      end
    end
    release_result();
    tests_run++;
    if ({bus.res_valid, busy} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL hold_release: valid=%b busy=%b, required 0 0", bus.res_valid, busy);
    end
  endtask

  task automatic test_overflow();
    string exp = "end end ";
    int    base4 = seq4.size();
    int    guard = 0;
    stub_verdict = 1'b1;
    send_str(1'b0, "end end\n");
    while (bus4.res_valid !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    tests_run++;
    if ({bus4.res_valid, bus4.res_ok, bus4.res_len} !== {1'b1, 1'b0, 8'd7}) begin
      tests_failed++;
      $display("[TB] FAIL ovf_max4: valid=%b ok=%b len=%0d, required 1 0 7", bus4.res_valid, bus4.res_ok, bus4.res_len);
    end
    tests_run++;
    if ({bus.res_ok, bus.res_len} !== {1'b1, 8'd7}) begin
      tests_failed++; $display("[TB] FAIL ovf_default: ok=%b len=%0d, required 1 7", bus.res_ok, bus.res_len);
    end
    tests_run++;
    if (seq4.size() - base4 != 8) begin
      tests_failed++; $display("[TB] FAIL ovf_seq_len: %0d chars, required 8", seq4.size() - base4);
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (seq4[base4 + i] !== exp[i]) begin
          tests_failed++; $display("[TB] FAIL ovf_seq[%0d]: %h, required %h", i, seq4[base4 + i], exp[i]);
        end
      end
    end
    release_result();
    send_str(1'b0, "abcd\n");
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus4.res_valid, bus4.res_ok, bus4.res_len} !== {1'b1, 1'b1, 8'd4}) begin
      tests_failed++;
      $display("[TB] FAIL ovf_at_limit: valid=%b ok=%b len=%0d, required 1 1 4", bus4.res_valid, bus4.res_ok, bus4.res_len);
    end
    release_result();
    send_str(1'b0, "abcde\n");
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus4.res_valid, bus4.res_ok, bus4.res_len} !== {1'b1, 1'b0, 8'd5}) begin
      tests_failed++;
      $display("[TB] FAIL ovf_past_limit: valid=%b ok=%b len=%0d, required 1 0 5", bus4.res_valid, bus4.res_ok, bus4.res_len);
    end
    release_result();
  endtask

  task automatic test_empty();
    int base = seq.size();
    stub_verdict = 1'b1;
    send_str(1'b0, "\n");
    repeat (2) @(negedge clk);
    tests_run++;
    if (seq.size() - base != 1) begin
      tests_failed++; $display("[TB] FAIL empty_seq_len: %0d chars, required 1", seq.size() - base);
    end else begin
      tests_run++;
      if (seq[base] !== 8'h20) begin
        tests_failed++; $display("[TB] FAIL empty_flush_char: %h, required 20", seq[base]);
      end
    end
    tests_run++;
    if ({bus.res_valid, bus.res_ok, bus.res_len} !== {1'b1, 1'b1, 8'd0}) begin
      tests_failed++;
      $display("[TB] FAIL empty_result: valid=%b ok=%b len=%0d, required 1 1 0", bus.res_valid, bus.res_ok, bus.res_len);
    end
    release_result();
    stub_verdict = 1'b0;
    send_str(1'b0, "\n");
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.res_valid, bus.res_ok, bus.res_len} !== {1'b1, 1'b0, 8'd0}) begin
      tests_failed++;
      $display("[TB] FAIL empty_bad_verdict: valid=%b ok=%b len=%0d, required 1 0 0", bus.res_valid, bus.res_ok, bus.res_len);
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    string exp = "end ";
    int    base;
    int    rbase = res_q.size();
    int    guard = 0;
    stub_verdict = 1'b1;
    send_str(1'b0, "be");
    bus.a_valid = 1'b1;
    bus.a_data  = 8'h67;
    while (bus.a_ready !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({bus.chk_clr, bus.chk_en, bus.res_valid, bus.a_ready, busy} !== 5'b10000) begin
      tests_failed++;
      $display("[TB] FAIL midreset: clr=%b en=%b valid=%b ar=%b busy=%b, required 1 0 0 0 0",
               bus.chk_clr, bus.chk_en, bus.res_valid, bus.a_ready, busy);
    end
    bus.a_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    base = seq.size();
    bus.res_ready = 1'b1;
    send_str(1'b1, "end\n");
    guard = 0;
    while (res_q.size() == rbase && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    bus.res_ready = 1'b0;
    tests_run++;
    if (res_q.size() - rbase != 1) begin
      tests_failed++; $display("[TB] FAIL midreset_count: %0d results, required 1", res_q.size() - rbase);
    end else begin
      tests_run++;
      if (res_q[rbase] !== res_t'({1'b1, 1'b1, 8'd3})) begin
        tests_failed++; $display("[TB] FAIL midreset_b_result: %h, required %h", res_q[rbase], res_t'({1'b1, 1'b1, 8'd3}));
      end
    end
    tests_run++;
    if (seq.size() - base != 4) begin
      tests_failed++; $display("[TB] FAIL midreset_seq_len: %0d chars, required 4", seq.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (seq[base + i] !== exp[i]) begin
          tests_failed++; $display("[TB] FAIL midreset_seq[%0d]: %h, required %h", i, seq[base + i], exp[i]);
        end
      end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_hold();
    test_overflow();
    test_empty();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/block_stream_ctrl.md
# block_stream_ctrl

Sentence-level controller that shares one begin/end nesting checker between two character sources. It arbitrates round-robin between sentence requesters and grants the checker to one source for a whole sentence. It clears the checker, streams the sentence into it, and appends a flushing space. It then reports a per-sentence verdict on a held result handshake. It sits between the character producers and the nesting checker, which is clocked from the same `clk`.

## Interface
- `MAX_LEN`, 200: maximum non-terminator characters per sentence; longer sentences are forced to a failing verdict.
- `TERM`, 8'h0A: sentence terminator character; consumed, never forwarded to the checker.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset asserted).
- `a_valid` in 1 / `a_data` in 8 / `a_ready` out 1: source A character stream. A transfer happens when valid and ready are both 1 at a rising edge.
- `b_valid` in 1 / `b_data` in 8 / `b_ready` out 1: source B character stream, same rules as A.
- `chk_clr` out 1: synchronous clear to the checker.
- `chk_en` out 1: the checker samples `chk_in` at a rising edge when this is 1.
- `chk_in` out 8: character to the checker.
- `chk_result` in 1: checker verdict for all characters sampled so far, valid the cycle after a sample.
- `res_valid` out 1 / `res_ready` in 1: verdict handshake.
- `res_src` out 1: owner of the reported sentence (0 = A, 1 = B).
- `res_ok` out 1: 1 = sentence well nested and within `MAX_LEN`.
- `res_len` out 8: count of non-terminator characters, saturating at 255.
- `busy` out 1: 1 whenever state ≠ IDLE.

## Operation
- FSM states: IDLE → GRANT → STREAM → FLUSH → SAMPLE → REPORT → IDLE.
- IDLE: no `*_ready`. A source is requesting when its `*_valid` is 1. With exactly one requester, that source is granted. With both requesting, the source other than the last owner is granted. After reset, A wins the first tie. The owner is latched and the FSM moves to GRANT. No data is consumed in IDLE.
- GRANT: one cycle. `chk_clr` = 1; the length counter and overflow flag are cleared. The FSM moves to STREAM.
- STREAM: owner's `*_ready` = 1; the other source's ready = 0.
  - Accepted non-`TERM` character: at the same edge, load `chk_en` = 1 and `chk_in` = char. Increment the length counter (saturating at 255). Set the overflow flag if the count exceeds `MAX_LEN`.
  - Accepted `TERM`: load `chk_en` = 1, `chk_in` = 8'h20 (the flush space), and move to FLUSH.
  - No transfer: `chk_en` loads 0.
- FLUSH: one cycle. The checker samples the space at the end of this cycle. `chk_en` loads 0. The FSM moves to SAMPLE.
- SAMPLE: one cycle. At its closing edge, capture `res_ok` = `chk_result` & ~overflow, `res_len`, and `res_src`. Set `res_valid`, move to REPORT, and update the round-robin pointer to the current owner.
- REPORT: `res_valid`/`res_src`/`res_ok`/`res_len` are held stable until `res_ready` = 1 at an edge. That edge clears `res_valid` and moves to IDLE.
- Overflow: characters are still consumed and forwarded until `TERM`. Only the verdict is forced to 0.
- An empty sentence (`TERM` first) still sends the flush space; `res_len` = 0 and the verdict comes from the checker.

## Timing
- `chk_en`, `chk_in`, `chk_clr` and all `res_*` outputs are registered. `*_ready` and `busy` are decoded from state and owner.
- Reset values: state IDLE; `chk_clr` = 1 while reset is asserted and until the first edge after release, then 0; `chk_en` = 0; `chk_in` = 0; `res_valid` = 0; `res_src` = 0; `res_ok` = 0; `res_len` = 0; `busy` = 0; both ready = 0; round-robin pointer set so A wins the first tie.
- Character accepted at edge k: `chk_en`/`chk_in` are driven during cycle k..k+1, and the checker samples at edge k+1. Throughput is one character per cycle.
- `TERM` accepted at edge t: flush sampled at t+1; result captured at t+2; `res_valid` = 1 from t+2.
- Grant latency: request seen in IDLE at edge g → `chk_clr` cycle g..g+1 → owner ready from g+1.
- Minimum sentence turnaround, with `res_ready` tied high: 6 cycles plus the sentence length.
- Reset asserted mid-sentence: immediate return to reset values. Any partial sentence is discarded; no verdict is issued.
- A requester's valid is ignored outside STREAM; deasserting valid mid-sentence simply stalls.

## Test plan
- Reset release, A sends "begin end\n": `chk_in` sequence b,e,g,i,n,' ',e,n,d,' '. `res_valid` rises 2 cycles after the `TERM` transfer with `res_src` = 0, `res_ok` = 1, `res_len` = 9.
- A and B both valid in IDLE from reset: A is granted first and B second. `res_src` reads 0 then 1, and `b_ready` stays 0 throughout A's sentence.
- A sends "begin\n" (checker returns 0): `res_ok` = 0, `res_len` = 5. Hold `res_ready` = 0 for 4 cycles: outputs are stable and `busy` = 1. One `res_ready` pulse returns the FSM to IDLE.
- `MAX_LEN` = 4, A sends "end end\n" and the checker returns 1: `res_ok` = 0, `res_len` = 7, and all 7 characters plus the flush space are forwarded.
- A sends "\n": exactly one `chk_en` cycle with `chk_in` = 8'h20; `res_len` = 0.
- Assert `reset` low while A's third character is in flight: `chk_clr` = 1, `chk_en` = 0, `res_valid` = 0, and `a_ready` = 0 immediately. After release, B is the only requester and is granted cleanly.
